// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin per-frame arbiter sharing one MAC transmit byte path
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   valid_in/last_in   per-source beat valid (also the request) and end-of-frame
//   data_in            packed source beats, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ready_out          per-source beat accept (only the owner sees tx_ready)
//   tx_data/valid/last beat to the MAC, tx_ready is the MAC accept
//   grant              registered one-hot owner, 0 when no frame is in flight
//   busy               high while a frame is in flight or the inter-frame gap runs
module tx_frame_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IFG_CYCLES = 12
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             valid_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  data_in,
    input  logic [NUM_PORTS-1:0]             last_in,
    output logic [NUM_PORTS-1:0]             ready_out,
    output logic [DATA_WIDTH-1:0]            tx_data,
    output logic                             tx_valid,
    output logic                             tx_last,
    input  logic                             tx_ready,
    output logic [NUM_PORTS-1:0]             grant,
    output logic                             busy
);
    localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    localparam int CW = IFG_CYCLES > 1 ? $clog2(IFG_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
    state_t state, state_n;
    logic [NUM_PORTS-1:0] grant_n, rot, low, pick;
    logic [2*NUM_PORTS-1:0] back;
    logic [PW:0] sh;
    logic [PW-1:0] ptr, ptr_n, gidx;
    logic [CW-1:0] cnt, cnt_n;
    // Rotate requests so the port after the last-served one sits at bit 0,
    // isolate the lowest set bit, then rotate that one-hot back into place.
    always_comb begin
        sh   = {1'b0, ptr} + 1'b1;
        rot  = NUM_PORTS'({valid_in, valid_in} >> sh);
        low  = rot & (~rot + NUM_PORTS'(1));
        back = {low, low} << sh;
        pick = back[2*NUM_PORTS-1:NUM_PORTS];
    end
    // grant is zero outside XFER, so gating every output by it idles the path
    always_comb begin
        gidx     = '0;
        tx_data  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                gidx    = PW'(i);
                tx_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        tx_valid  = |(grant & valid_in);
        tx_last   = |(grant & last_in);
        ready_out = grant & {NUM_PORTS{tx_ready}};
        busy      = state != IDLE;
    end
    always_comb begin
        state_n = state;
        grant_n = grant;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (|valid_in) begin
                    grant_n = pick;
                    state_n = XFER;
                end
            end
            XFER: begin
                if (tx_valid && tx_ready && tx_last) begin
                    ptr_n   = gidx;
                    grant_n = '0;
                    cnt_n   = CW'(IFG_CYCLES - 1);
                    state_n = IFG_CYCLES == 0 ? IDLE : GAP;
                end
            end
            GAP: begin
                cnt_n   = cnt == '0 ? cnt : cnt - CW'(1);
                state_n = cnt == '0 ? IDLE : GAP;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= PW'(NUM_PORTS - 1);
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: randomized check of two arbiters (IFG 12 and IFG 0) against a frame-level model
module tb_tx_frame_arbiter;
    localparam int NP = 4;
    localparam int DW = 8;
    logic clock = 0;
    logic reset = 1;
    logic [NP-1:0]    valid_in [2];
    logic [NP-1:0]    last_in [2];
    logic [NP*DW-1:0] data_in [2];
    logic [NP-1:0]    ready_out [2];
    logic [NP-1:0]    grant [2];
    logic [DW-1:0]    tx_data [2];
    logic             tx_valid [2];
    logic             tx_last [2];
    logic             tx_ready [2];
    logic             busy [2];
    int checks = 0;
    int errors = 0;
    int owner [2];
    int ptr [2];
    int free_at [2];
    int cur [2];
    int frames_exp [2];
    int frames_got [2];
    int rem [2][NP];
    logic [DW-1:0] dat [2][NP];
    int vld_pct, rdy_pct, maxlen;
    logic [NP-1:0] vmask;

    tx_frame_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .IFG_CYCLES(12)) dut0 (
        .clock(clock), .reset(reset), .valid_in(valid_in[0]), .data_in(data_in[0]),
        .last_in(last_in[0]), .ready_out(ready_out[0]), .tx_data(tx_data[0]),
        .tx_valid(tx_valid[0]), .tx_last(tx_last[0]), .tx_ready(tx_ready[0]),
        .grant(grant[0]), .busy(busy[0]));
    tx_frame_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .IFG_CYCLES(0)) dut1 (
        .clock(clock), .reset(reset), .valid_in(valid_in[1]), .data_in(data_in[1]),
        .last_in(last_in[1]), .ready_out(ready_out[1]), .tx_data(tx_data[1]),
        .tx_valid(tx_valid[1]), .tx_last(tx_last[1]), .tx_ready(tx_ready[1]),
        .grant(grant[1]), .busy(busy[1]));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ifg(int u);
        return u == 0 ? 12 : 0;
    endfunction

    function automatic int rr_pick(int p, logic [NP-1:0] v);
        for (int k = 1; k <= NP; k++)
            if (v[(p + k) % NP]) return (p + k) % NP;
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            owner[u]   = -1;
            ptr[u]     = NP - 1;
            free_at[u] = 0;
            cur[u]     = 0;
        end
    endtask

    task automatic drive();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < NP; i++) begin
                if (rem[u][i] == 0) rem[u][i] = $urandom_range(maxlen, 1);
                valid_in[u][i] = vmask[i] && ($urandom_range(99, 0) < vld_pct);
                last_in[u][i]  = rem[u][i] == 1;
                data_in[u][i*DW +: DW] = dat[u][i];
            end
            tx_ready[u] = $urandom_range(99, 0) < rdy_pct;
        end
    endtask

    task automatic check_all(int u);
        int o;
        logic [NP-1:0] eg;
        o  = owner[u];
        eg = '0;
        if (o >= 0) eg[o] = 1'b1;
        check($sformatf("grant%0d", u), grant[u], eg);
        check($sformatf("ready_out%0d", u), ready_out[u], tx_ready[u] ? eg : '0);
        check($sformatf("tx_valid%0d", u), tx_valid[u], o >= 0 && valid_in[u][o]);
        check($sformatf("tx_last%0d", u), tx_last[u], o >= 0 && last_in[u][o]);
        check($sformatf("tx_data%0d", u), tx_data[u], o >= 0 ? data_in[u][o*DW +: DW] : '0);
        check($sformatf("busy%0d", u), busy[u], o >= 0 || cur[u] < free_at[u] - 1);
        if (tx_valid[u] && tx_ready[u] && tx_last[u]) frames_got[u]++;
    endtask

    task automatic update(int u);
        int o;
        cur[u]++;
        o = owner[u];
        if (o >= 0) begin
            if (valid_in[u][o] && tx_ready[u]) begin
                dat[u][o] = DW'($urandom);
                rem[u][o]--;
                if (last_in[u][o]) begin
                    frames_exp[u]++;
                    ptr[u]     = o;
                    owner[u]   = -1;
                    free_at[u] = cur[u] + ifg(u) + 1;
                end
            end
        end else if (cur[u] >= free_at[u] && valid_in[u] != '0) begin
            owner[u] = rr_pick(ptr[u], valid_in[u]);
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        for (int u = 0; u < 2; u++) check_all(u);
        @(posedge clock);
        for (int u = 0; u < 2; u++) update(u);
        #1;
    endtask

    task automatic phase(int n, int v, int r, int ml, logic [NP-1:0] m);
        vld_pct = v;
        rdy_pct = r;
        maxlen  = ml;
        vmask   = m;
        repeat (n) cycle();
    endtask

    task automatic reset_test();
        int n = 0;
        phase(0, 90, 70, 4, 4'b0100);
        while (!(owner[0] == 2 && rem[0][2] > 1) && n < 400) begin
            cycle();
            n++;
        end
        check("rst_setup", owner[0] == 2, 1'b1);
        drive();
        #1;
        for (int u = 0; u < 2; u++) check_all(u);
        #1 reset = 0;
        #1;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("rst_grant%0d", u), grant[u], '0);
            check($sformatf("rst_ready%0d", u), ready_out[u], '0);
            check($sformatf("rst_valid%0d", u), tx_valid[u], 1'b0);
            check($sformatf("rst_busy%0d", u), busy[u], 1'b0);
        end
        repeat (2) @(posedge clock);
        #3 reset = 1;
        model_reset();
        phase(1, 100, 100, 4, '1);
        check("first_grant_after_rst", grant[0], 4'b0001);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            frames_exp[u] = 0;
            frames_got[u] = 0;
            for (int i = 0; i < NP; i++) begin
                rem[u][i] = 0;
                dat[u][i] = DW'($urandom);
            end
            valid_in[u] = '1;
            last_in[u]  = '1;
            data_in[u]  = '1;
            tx_ready[u] = 1'b1;
        end
        #1 reset = 0;
        #1;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("reset_grant%0d", u), grant[u], '0);
            check($sformatf("reset_ready%0d", u), ready_out[u], '0);
            check($sformatf("reset_valid%0d", u), tx_valid[u], 1'b0);
            check($sformatf("reset_data%0d", u), tx_data[u], '0);
            check($sformatf("reset_busy%0d", u), busy[u], 1'b0);
        end
        #10 reset = 1;
        model_reset();
        phase(150, 100, 100, 3, 4'b0101);
        phase(600, 70, 70, 4, '1);
        phase(200, 100, 100, 1, '1);
        phase(400, 60, 30, 4, '1);
        phase(300, 50, 90, 3, '1);
        reset_test();
        phase(200, 100, 100, 2, 4'b1001);
        phase(400, 80, 60, 4, '1);
        for (int u = 0; u < 2; u++)
            check($sformatf("frames%0d", u), frames_got[u], frames_exp[u]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
